// File: rtl/sa_drain_pkg.sv
// Shared types and sizes for the systolic-array output drain path.
package sa_drain_pkg;
  localparam int SA_ROW_NUM      = 16;
  localparam int SA_OUT_WIDTH    = 1024;
  localparam int SA_OUT_WIDTH_88 = 768;
  localparam int SA_FIFO_DEPTH   = 4;
  localparam int ROW_W           = $clog2(SA_ROW_NUM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAIN,
    S_FLUSH
  } drain_state_e;
endpackage

// File: rtl/sa_out_drain_fifo.sv
// Small synchronous FIFO; status flags are registers, read data is a flop mux
// zeroed while empty so the stream bus idles at 0.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        push, pop;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10: begin
          count <= count + 1'b1;
          empty <= 1'b0;
          full  <= (count == CW'(DEPTH - 1));
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CW'(1));
        end
        default: ;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/sa_out_drain.sv
// Drains the 16 result rows of the systolic array through a small FIFO onto a
// valid/ready stream, keeping the array's channel-out counter in step.
module sa_out_drain
  import sa_drain_pkg::*;
#(
  parameter int ROW_NUM      = SA_ROW_NUM,
  parameter int OUT_WIDTH    = SA_OUT_WIDTH,
  parameter int OUT_WIDTH_88 = SA_OUT_WIDTH_88,
  parameter int FIFO_DEPTH   = SA_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  output logic                 busy,
  output logic                 done,
  output logic                 sa_channel_out_reset,
  output logic                 sa_channel_out_en,
  input  logic [OUT_WIDTH-1:0] sa_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]     out_row_idx,
  output logic                 out_last
);
  localparam int WORD_W = OUT_WIDTH + ROW_W + 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  drain_state_e         state, state_nxt;
  logic                 mode_q, done_q;
  logic [ROW_W-1:0]     row_cnt;
  logic                 row_is_last, last_push, pop;
  logic [OUT_WIDTH-1:0] row_mask;
  logic [WORD_W-1:0]    fifo_wr, fifo_rd;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;

  assign row_is_last = (row_cnt == ROW_W'(ROW_NUM - 1));
  assign pop         = out_valid && out_ready;

  // Enable gated by the registered full flag: no pass-through when full.
  assign sa_channel_out_en    = !reset && (state == S_DRAIN) && !fifo_full;
  assign sa_channel_out_reset = reset || (state == S_CLEAR);
  assign last_push            = sa_channel_out_en && row_is_last;

  // 8x8 mode only drives the low 768 bits; the rest of the bus is don't-care.
  assign row_mask = mode_q ? {OUT_WIDTH{1'b1}}
                           : {{(OUT_WIDTH-OUT_WIDTH_88){1'b0}}, {OUT_WIDTH_88{1'b1}}};
  assign fifo_wr  = {row_is_last, row_cnt, sa_out & row_mask};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_DRAIN;
      S_DRAIN: if (last_push) state_nxt = S_FLUSH;
      S_FLUSH: if (fifo_empty || (fifo_count == CW'(1) && pop)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      row_cnt <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == S_FLUSH) && (state_nxt == S_IDLE);
      if (state == S_IDLE && start) mode_q <= mode;
      if (state == S_CLEAR)
        row_cnt <= '0;
      else if (sa_channel_out_en)
        row_cnt <= row_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (sa_channel_out_en),
    .wr_data (fifo_wr),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign out_valid = !fifo_empty;
  assign {out_last, out_row_idx, out_data} = fifo_rd;
endmodule

// File: tb/tb_sa_out_drain.sv
// Bench for sa_out_drain: array counter model, row scoreboard, timing checks.
module tb_sa_out_drain;
  import sa_drain_pkg::*;
  localparam int W = SA_OUT_WIDTH;

  typedef struct packed {
    logic         last;
    logic [3:0]   idx;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic         busy, done, sa_channel_out_reset, sa_channel_out_en;
  logic         out_valid, out_last;
  logic [W-1:0] sa_out, out_data;
  logic [3:0]   out_row_idx;

  int           n_chk = 0, n_pass = 0, pass_words = 0;
  exp_t         sb[$];
  exp_t         e_m;
  logic [3:0]   arr_cnt;
  logic [31:0]  key = '0;
  logic         allones = 1'b0;
  logic         hold_v = 1'b0, hold_l;
  logic [W-1:0] hold_d;
  logic [3:0]   hold_i;

  always #5 clk = ~clk;

  sa_out_drain dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .sa_channel_out_reset(sa_channel_out_reset), .sa_channel_out_en(sa_channel_out_en),
    .sa_out(sa_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_idx(out_row_idx), .out_last(out_last)
  );

  function automatic logic [W-1:0] gen(input logic [3:0] r, input logic [31:0] k, input logic ones);
    if (ones) return '1;
    return {(W/8){4'h0, r}} ^ {(W/32){k}};
  endfunction

  // Array side: channel-out counter and combinational row bus.
  always @(posedge clk)
    if (sa_channel_out_reset) arr_cnt <= '0;
    else if (sa_channel_out_en) arr_cnt <= arr_cnt + 1'b1;
  assign sa_out = gen(arr_cnt, key, allones);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int ch;
    n_chk++;
    if (obs === exp) n_pass++;
    else begin
      ch = 0;
      for (int i = W/64-1; i >= 0; i--) if (obs[i*64 +: 64] !== exp[i*64 +: 64]) ch = i;
      $display("FAIL %s: chunk %0d got %h expected %h", tag, ch, obs[ch*64 +: 64], exp[ch*64 +: 64]);
    end
  endtask

  task automatic push_exp(input logic m);
    logic [W-1:0] v;
    for (int r = 0; r < 16; r++) begin
      v = gen(4'(r), key, allones);
      if (!m) for (int b = 768; b < 1024; b++) v[b] = 1'b0;
      sb.push_back({(r == 15), 4'(r), v});
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic m);
    mode = m; start = 1'b1; push_exp(m);
    cyc(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int c = 0;
    while (!done && c < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      cyc(); c++;
    end
    chk("done_timeout", W'(done), W'(1'b1));
    out_ready = 1'b1;
  endtask

  // Stream monitor: scoreboard pop, hold-stable checks, words per pass.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete(); pass_words = 0; hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", W'(out_valid), W'(1'b1));
        chk("hold_data", out_data, hold_d);
        chk("hold_idx", W'(out_row_idx), W'(hold_i));
        chk("hold_last", W'(out_last), W'(hold_l));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_extra_word", W'(out_row_idx), W'(5'h1f));
        else begin
          e_m = sb.pop_front();
          chk("row_data", out_data, e_m.data);
          chk("row_idx", W'(out_row_idx), W'(e_m.idx));
          chk("row_last", W'(out_last), W'(e_m.last));
        end
        pass_words++;
      end
      if (done) begin
        chk("words_per_pass", W'(pass_words), W'(16));
        pass_words = 0;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data; hold_i = out_row_idx; hold_l = out_last;
    end
  end

  initial begin
    int en_n, en_f, en_l, v_f, v_l, d_c;
    logic d_busy;
    // Reset state
    repeat (3) cyc();
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_en", W'(sa_channel_out_en), '0);
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_idx", W'(out_row_idx), '0);
    chk("rst_last", W'(out_last), '0);
    chk("rst_chreset", W'(sa_channel_out_reset), W'(1'b1));
    reset = 1'b0; cyc();
    chk("idle_chreset", W'(sa_channel_out_reset), '0);

    // Basic pass, mode 1, ready held high: cycle-exact timing
    launch(1'b1);
    chk("clear_pulse", W'(sa_channel_out_reset), W'(1'b1));
    chk("busy_c1", W'(busy), W'(1'b1));
    en_n = 0; en_f = -1; en_l = -1; v_f = -1; v_l = -1; d_c = -1; d_busy = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) cyc();
      if (sa_channel_out_en) begin en_n++; if (en_f < 0) en_f = c; en_l = c; end
      if (out_valid) begin if (v_f < 0) v_f = c; v_l = c; end
      if (done && d_c < 0) begin d_c = c; d_busy = busy; end
    end
    chk("en_count", W'(en_n), W'(16));
    chk("en_first", W'(en_f), W'(2));
    chk("en_last", W'(en_l), W'(17));
    chk("valid_first", W'(v_f), W'(3));
    chk("valid_last", W'(v_l), W'(18));
    chk("done_cycle", W'(d_c), W'(19));
    chk("busy_at_done", W'(d_busy), '0);

    // Mode 0 mask with all-ones array output
    allones = 1'b1; launch(1'b0); wait_done(100, 1'b0); allones = 1'b0;

    // Backpressure: ready low for cycles 0..30
    key = 32'hA5A5_0F0F; out_ready = 1'b0; launch(1'b1);
    en_n = 0; en_f = -1; en_l = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) cyc();
      if (sa_channel_out_en) begin en_n++; if (en_f < 0) en_f = c; en_l = c; end
    end
    chk("bp_en_count", W'(en_n), W'(4));
    chk("bp_en_first", W'(en_f), W'(2));
    chk("bp_en_last", W'(en_l), W'(5));
    chk("bp_valid", W'(out_valid), W'(1'b1));
    out_ready = 1'b1; wait_done(100, 1'b0);

    // Random ready over 100 passes, alternating modes
    for (int p = 0; p < 100; p++) begin
      key = $urandom; launch(1'(p % 2)); wait_done(600, 1'b1);
    end

    // Start while busy is ignored; start in the done cycle launches again
    key = 32'h1234_5678; launch(1'b1);
    repeat (7) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    wait_done(100, 1'b0);
    launch(1'b1);
    chk("b2b_clear", W'(sa_channel_out_reset), W'(1'b1));
    chk("b2b_busy", W'(busy), W'(1'b1));
    wait_done(100, 1'b0);

    // Reset mid-DRAIN
    key = 32'hDEAD_BEEF; launch(1'b1);
    repeat (8) cyc();
    chk("mid_drain_en", W'(sa_channel_out_en), W'(1'b1));
    reset = 1'b1; cyc();
    chk("rst_mid_valid", W'(out_valid), '0);
    chk("rst_mid_chreset", W'(sa_channel_out_reset), W'(1'b1));
    chk("rst_mid_busy", W'(busy), '0);
    chk("rst_mid_en", W'(sa_channel_out_en), '0);
    cyc(); reset = 1'b0; cyc();
    chk("post_rst_chreset", W'(sa_channel_out_reset), '0);
    chk("post_rst_arr_cnt", W'(arr_cnt), '0);
    key = 32'h0F1E_2D3C; launch(1'b1); wait_done(100, 1'b0);
    cyc();
    chk("sb_drained", W'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
